// File: rtl/move_scan_sequencer.sv
// Move-generation pass sequencer: clears the square array, lets ray/knight propagation
// settle, then walks every (square, direction) slot and streams same-colour moves out.
module move_scan_sequencer #(
    parameter int NUM_SQUARES   = 64,
    parameter int NUM_DIRS      = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             engine_color,
    output logic             sq_clear,
    output logic             sq_enable,
    output logic [5:0]       sq_sel,
    output logic [3:0]       dir_sel,
    input  logic [31:0]      slot_word,
    output logic [31:0]      mv_data,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] move_count
);

    localparam int         SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [9:0] LAST_IDX = 10'(NUM_SQUARES * NUM_DIRS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic              color, color_next;
    logic [SET_W-1:0]  settle_cnt, settle_next;
    logic [9:0]        idx, idx_next;
    logic              tail, tail_next;
    logic [31:0]       data_next;
    logic              valid_next;
    logic [CNT_W-1:0]  count_next;
    logic              is_move;
    logic              out_free;
    logic              advance;

    assign sq_sel  = idx[9:4];
    assign dir_sel = idx[3:0];

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state      <= S_IDLE;
            color      <= 1'b0;
            settle_cnt <= '0;
            idx        <= '0;
            tail       <= 1'b0;
            mv_data    <= '0;
            mv_valid   <= 1'b0;
            move_count <= '0;
        end else begin
            state      <= state_next;
            color      <= color_next;
            settle_cnt <= settle_next;
            idx        <= idx_next;
            tail       <= tail_next;
            mv_data    <= data_next;
            mv_valid   <= valid_next;
            move_count <= count_next;
        end
    end

    // tail marks that the final slot has been consumed; the extra SCAN cycle it
    // produces is where a still-pending last beat is drained before DONE.
    always_comb begin
        state_next  = state;
        color_next  = color;
        settle_next = settle_cnt;
        idx_next    = idx;
        tail_next   = tail;
        data_next   = mv_data;
        valid_next  = mv_valid;
        count_next  = move_count;
        advance     = 1'b0;
        sq_clear    = 1'b0;
        sq_enable   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        is_move  = (slot_word != 32'd0) && (slot_word[13] == color);
        out_free = !mv_valid || mv_ready;

        case (state)
            S_IDLE: begin
                if (start) begin
                    color_next = engine_color;
                    count_next = '0;
                    idx_next   = '0;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                sq_clear    = 1'b1;
                busy        = 1'b1;
                settle_next = '0;
                state_next  = S_SETTLE;
            end
            S_SETTLE: begin
                sq_enable = 1'b1;
                busy      = 1'b1;
                if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                    idx_next   = '0;
                    tail_next  = 1'b0;
                    state_next = S_SCAN;
                end else begin
                    settle_next = settle_cnt + SET_W'(1);
                end
            end
            S_SCAN: begin
                sq_enable = 1'b1;
                busy      = 1'b1;
                if (tail) begin
                    if (out_free) begin
                        valid_next = 1'b0;
                        state_next = S_DONE;
                    end
                end else begin
                    if (is_move) begin
                        if (out_free) begin
                            data_next  = slot_word;
                            valid_next = 1'b1;
                            advance    = 1'b1;
                            if (move_count != {CNT_W{1'b1}}) begin
                                count_next = move_count + CNT_W'(1);
                            end
                        end
                    end else begin
                        advance = 1'b1;
                        if (mv_valid && mv_ready) begin
                            valid_next = 1'b0;
                        end
                    end
                    if (advance) begin
                        if (idx == LAST_IDX) begin
                            tail_next = 1'b1;
                        end else begin
                            idx_next = idx + 10'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_move_scan_sequencer.sv
// Directed bench for move_scan_sequencer: a behavioural board memory feeds slot_word
// and every check is an immediate assertion against hand-computed values.
module tb_move_scan_sequencer;

    logic        clk;
    logic        clear_n;
    logic        start;
    logic        engine_color;
    logic        sq_clear;
    logic        sq_enable;
    logic [5:0]  sq_sel;
    logic [3:0]  dir_sel;
    logic [31:0] slot_word;
    logic [31:0] mv_data;
    logic        mv_valid;
    logic        mv_ready;
    logic        busy;
    logic        done;
    logic [7:0]  move_count;

    logic [31:0] board [0:1023];
    logic [31:0] beat_q [$];
    int          cyc;
    int          n_cmp;
    int          n_err;

    move_scan_sequencer dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .start        (start),
        .engine_color (engine_color),
        .sq_clear     (sq_clear),
        .sq_enable    (sq_enable),
        .sq_sel       (sq_sel),
        .dir_sel      (dir_sel),
        .slot_word    (slot_word),
        .mv_data      (mv_data),
        .mv_valid     (mv_valid),
        .mv_ready     (mv_ready),
        .busy         (busy),
        .done         (done),
        .move_count   (move_count)
    );

    assign slot_word = board[{sq_sel, dir_sel}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A beat is logged when valid and ready are both seen just before the edge that accepts it.
    task automatic step();
        if (mv_valid && mv_ready) beat_q.push_back(mv_data);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_sq_clear"}, 32'(sq_clear), 32'd0);
        check({tag, "_sq_enable"}, 32'(sq_enable), 32'd0);
        check({tag, "_sq_sel"}, 32'(sq_sel), 32'd0);
        check({tag, "_dir_sel"}, 32'(dir_sel), 32'd0);
        check({tag, "_mv_data"}, mv_data, 32'd0);
        check({tag, "_mv_valid"}, 32'(mv_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_move_count"}, 32'(move_count), 32'd0);
    endtask

    task automatic start_pass(input logic color);
        engine_color = color;
        start        = 1'b1;
        cyc          = 0;
        beat_q.delete();
        step();
        start        = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycle);
        while (!done && cyc < 3000) step();
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cycle));
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 1024; i++) board[i] = 32'd0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        cyc          = 0;
        clear_n      = 1'b0;
        start        = 1'b1;
        engine_color = 1'($urandom);
        mv_ready     = 1'($urandom);
        for (int i = 0; i < 1024; i++) board[i] = $urandom;

        // Reset with random inputs and start asserted
        step();
        engine_color = 1'($urandom);
        mv_ready     = 1'($urandom);
        step();
        check_idle_zero("reset");
        clear_n = 1'b1;
        start   = 1'b0;
        step();
        check("start_during_reset_ignored", 32'(busy), 32'd0);

        // Empty board, black to move
        clear_board();
        mv_ready = 1'b1;
        start_pass(1'b0);
        check("empty_c1_sq_clear", 32'(sq_clear), 32'd1);
        check("empty_c1_sq_enable", 32'(sq_enable), 32'd0);
        check("empty_c1_busy", 32'(busy), 32'd1);
        step();
        check("empty_c2_sq_clear", 32'(sq_clear), 32'd0);
        check("empty_c2_sq_enable", 32'(sq_enable), 32'd1);
        while (cyc < 10) step();
        check("empty_c10_dir_sel", 32'(dir_sel), 32'd0);
        step();
        check("empty_c11_dir_sel", 32'(dir_sel), 32'd1);
        wait_done("empty", 1035);
        check("empty_beats", 32'(beat_q.size()), 32'd0);
        check("empty_move_count", 32'(move_count), 32'd0);

        // Two black moves, consumer always ready
        board[20 * 16 + 1] = 32'h0014_0714;
        board[43 * 16 + 9] = 32'h0000_012B;
        start_pass(1'b0);
        wait_done("two", 1035);
        check("two_beats", 32'(beat_q.size()), 32'd2);
        if (beat_q.size() == 2) begin
            check("two_beat0", beat_q[0], 32'h0014_0714);
            check("two_beat1", beat_q[1], 32'h0000_012B);
        end
        check("two_move_count", 32'(move_count), 32'd2);
        step();
        step();
        check("two_count_held", 32'(move_count), 32'd2);

        // Same board, white to move: both words are black pieces
        start_pass(1'b1);
        wait_done("white", 1035);
        check("white_beats", 32'(beat_q.size()), 32'd0);
        check("white_move_count", 32'(move_count), 32'd0);

        // Backpressure: first beat stays pending until the scan stalls on the second move
        mv_ready = 1'b0;
        start_pass(1'b0);
        while (cyc < 707) step();
        for (int k = 0; k < 6; k++) begin
            check("bp_sq_sel", 32'(sq_sel), 32'd43);
            check("bp_dir_sel", 32'(dir_sel), 32'd9);
            check("bp_mv_valid", 32'(mv_valid), 32'd1);
            check("bp_mv_data", mv_data, 32'h0014_0714);
            if (k < 5) step();
        end
        mv_ready = 1'b1;
        wait_done("bp", 1040);
        check("bp_beats", 32'(beat_q.size()), 32'd2);
        if (beat_q.size() == 2) begin
            check("bp_beat0", beat_q[0], 32'h0014_0714);
            check("bp_beat1", beat_q[1], 32'h0000_012B);
        end
        check("bp_move_count", 32'(move_count), 32'd2);

        // Abort in the middle of the scan
        clear_board();
        start_pass(1'b0);
        while (sq_sel != 6'd30 && cyc < 2000) step();
        check("abort_reached_sq30", 32'(sq_sel), 32'd30);
        clear_n = 1'b0;
        step();
        check_idle_zero("abort");
        clear_n = 1'b1;
        step();
        check("abort_stays_idle", 32'(busy), 32'd0);

        // start pulsed during SETTLE must not disturb the pass
        start_pass(1'b0);
        while (cyc < 5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start_still_enable", 32'(sq_enable), 32'd1);
        wait_done("busy_start", 1035);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/move_scan_sequencer.md
Name: move_scan_sequencer

Overview:
- Sequences one move-generation pass over the square array: clears all square registers, enables ray/knight propagation until it settles, then scans every square's 16 direction move outputs.
- Filters out empty slots and moves of the wrong colour, and streams valid 32-bit move words to the search engine over a valid/ready interface.
- Sits between the board array (move-output mux addressed by sq_sel/dir_sel) and the move FIFO / search front end.

Parameters:
- NUM_SQUARES, 64, squares scanned (sq_sel range 0..NUM_SQUARES-1)
- NUM_DIRS, 16, move slots per square (8 sliding U,D,L,R,UL,UR,DL,DR; 8 knight UUL,UUR,LLU,RRU,DDL,DDR,LLD,RRD; index order as listed)
- SETTLE_CYCLES, 8, enable cycles before scanning (7 ray hops + 1 register stage)
- CNT_W, 8, width of move_count

Ports:
- clk  in  1  clock; all state updates on rising edge
- clear_n  in  1  synchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- engine_color  in  1  side to move (1=WHITE, 0=BLACK); sampled at start
- sq_clear  out  1  clear to all square registers
- sq_enable  out  1  enable to all square registers
- sq_sel  out  6  square index driven to the move-output mux
- dir_sel  out  4  direction slot driven to the mux
- slot_word  in  32  move word for (sq_sel, dir_sel), combinational from the mux, same cycle
- mv_data  out  32  move word to consumer
- mv_valid  out  1  mv_data valid
- mv_ready  in  1  consumer accepts; transfer when mv_valid & mv_ready
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- move_count  out  CNT_W  moves emitted this pass

Behaviour:
- Reset (clear_n=0 at edge): state IDLE; sq_clear, sq_enable, sq_sel, dir_sel, mv_data, mv_valid, busy, done, move_count all 0. Overrides everything, including a pass in progress; a held mv_valid beat is dropped.
- Move word fields: [29:24] captured piece, [21:16] final square, [13:8] initial piece ([13]=colour), [5:0] initial square. A slot is a move iff slot_word != 0 and slot_word[13] == latched engine_color.
- FSM states and transitions:
  - IDLE: busy=0. On start=1, latch engine_color, clear move_count, go to CLEAR.
  - CLEAR: exactly 1 cycle; sq_clear=1, sq_enable=0, busy=1. Then go to SETTLE.
  - SETTLE: exactly SETTLE_CYCLES cycles; sq_enable=1. Then go to SCAN with sq_sel=0, dir_sel=0.
  - SCAN: sq_enable stays 1 so square outputs are stable. Slot index = {sq_sel, dir_sel}; dir_sel is least significant.
  - DONE: 1 cycle; done=1, busy=1. Then go to IDLE.
- SCAN, per cycle, where out_free = !mv_valid | mv_ready:
  - slot is a move and out_free: load mv_data <= slot_word, set mv_valid=1, increment move_count (saturates at 2^CNT_W-1), advance index.
  - slot is a move and !out_free: hold index, mv_data and mv_valid.
  - slot not a move: advance index; if mv_valid & mv_ready, clear mv_valid.
- mv_data must not change while mv_valid=1 and mv_ready=0.
- Leaving SCAN: after the last slot (63,15) is processed, go to DONE only when the output register is empty or draining that cycle. Otherwise stay in SCAN holding the index until the beat is accepted.
- Index wrap: dir_sel 15 -> 0 with sq_sel+1. No advance past (63,15).
- start outside IDLE: ignored. start and clear_n=0 at the same edge: reset wins.
- Latency: with start sampled at edge 0 and no backpressure, sq_clear is high in cycle 1, sq_enable rises in cycle 2, and the first slot is addressed in cycle 2+SETTLE_CYCLES. done fires at cycle 3+SETTLE_CYCLES+NUM_SQUARES*NUM_DIRS (=1035 at defaults).
- move_count holds its value after done until the next start.

Test Plan:
- Reset: hold clear_n=0 for 2 cycles with random inputs -> every output 0, state IDLE; start in the same cycle as clear_n=0 is ignored.
- Empty board: all slot_word=0, engine_color=BLACK, start -> sq_clear for 1 cycle, sq_enable for 8 cycles before scanning, no mv_valid, done at cycle 1035, move_count=0.
- Two moves, mv_ready=1:
  - slot (20,1)=32'h0014_0714 (black rook), slot (43,9)=32'h0000_012B (black knight), engine_color=0.
  - Required: mv_data beats 0x0014_0714 then 0x0000_012B in that order; move_count=2.
- Colour filter: same board with engine_color=WHITE (bit13=0 in both words) -> no beats, move_count=0.
- Backpressure: mv_ready=0 for 5 cycles while the first beat is valid -> mv_data/mv_valid/sq_sel/dir_sel frozen; after mv_ready=1 both beats delivered, none lost or duplicated.
- Abort and busy-start:
  - clear_n=0 during SCAN at sq_sel=30 -> next cycle IDLE, all outputs 0.
  - start pulsed during SETTLE -> no restart; pass timing unchanged.
